code_step_monitor: RTL and testbench
====================================

// Module: code_step_monitor
// PURPOSE
//  Streaming front end for the 3-bit code relation classifier. Accepts one 3-bit
//  code per valid cycle, pairs it with the previously accepted code, and issues a
//  registered classification of each step (A = new code, B = previous code).
//  Also tracks runs of like-class steps, flags lock, and counts unrelated steps.
// PARAMETERS
//  RUN_W     4  width of run_len; run_len saturates at 2**RUN_W-1
//  LOCK_LEN  4  run length at which lock asserts; legal 1..2**RUN_W-1
//  CNT_W     8  width of err_cnt; saturating
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  clear        in   1      synchronous soft clear, active-high
//  in_valid     in   1      in_code valid this cycle
//  in_code      in   3      new code sample (A)
//  out_valid    out  1      one-cycle pulse: flags/run outputs updated
//  gray         out  1      A,B differ in exactly one bit
//  excess_3     out  1      |A-B| == 3 (unsigned, no wrap)
//  more         out  1      A-B == 1
//  less         out  1      B-A == 1
//  no_relation  out  1      none of gray/excess_3/more/less
//  run_class    out  2      0 NONE, 1 UP, 2 DOWN, 3 GRAY
//  run_len      out  RUN_W  consecutive steps of run_class
//  lock         out  1      run_class!=NONE && run_len>=LOCK_LEN
//  err_cnt      out  CNT_W  count of no_relation steps
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=EMPTY, prev=0; every output 0. Overrides clear.
//  FSM: EMPTY -(in_valid & !clear)-> HAVE_PREV: store in_code as prev; no out_valid.
//    HAVE_PREV + in_valid & !clear: classify(in_code, prev), prev<=in_code,
//    out_valid=1 on the next cycle (latency 1); stay HAVE_PREV.
//    any state + clear: -> EMPTY, prev=0, run_class/run_len/lock/err_cnt=0,
//    flags=0, out_valid=0; a same-cycle in_valid sample is discarded.
//  in_valid=0: out_valid=0; flags, run outputs, err_cnt hold.
//  Flags are independent (e.g. 7->6 sets gray and less); no_relation exclusive.
//  Arithmetic on zero-extended 4-bit values; 0->7 is not more/less (no wrap).
//  Step class priority: more->UP, else less->DOWN, else gray->GRAY, else NONE.
//  Run update per classified step: class NONE -> run_len=0;
//    class==run_class -> run_len+1, saturate at 2**RUN_W-1, no wrap;
//    else run_len=1. run_class<=class. lock registered with run outputs.
//  err_cnt += no_relation, saturating at 2**CNT_W-1; excess_3 alone is not error.
//  Repeated code (A==B): all four relations 0 -> no_relation=1, class NONE.
// TESTING
//  1. Reset; codes 0,1,2,3,4 -> 4 out_valid pulses, more=1, run UP,
//     run_len 1,2,3,4, lock=1 only on 4th.
//  2. Codes 7,6 -> gray=1, less=1, no_relation=0, run_class=DOWN, run_len=1.
//  3. Codes 0,2,6,4 -> gray only each step, run_class=GRAY, run_len 1,2,3, lock=0.
//  4. Codes 1,4 -> excess_3=1, gray=0, no_relation=0, run_class=NONE, run_len=0,
//     err_cnt unchanged; then 0->7 -> no_relation=1, err_cnt+1.
//  5. Alternate 0,7 for 300 steps -> err_cnt sticks at 255; RUN_W=4 long UP/DOWN
//     mix never wraps run_len past 15.
//  6. Mid-run (lock=1) assert clear with in_valid=1 -> all outputs 0 next cycle,
//     sample dropped; next valid produces no out_valid; repeat with rst_n=0.

Source files
------------

// File: rtl/code_step_monitor.sv
// code_step_monitor: classifies each step between consecutive 3-bit codes and tracks like-class runs
module code_step_monitor #(
  parameter int RUN_W    = 4,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             out_valid,
  output logic             gray,
  output logic             excess_3,
  output logic             more,
  output logic             less,
  output logic             no_relation,
  output logic [1:0]       run_class,
  output logic [RUN_W-1:0] run_len,
  output logic             lock,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic {EMPTY, HAVE_PREV} state_t;
  localparam logic [1:0] NONE = 2'd0, UP = 2'd1, DOWN = 2'd2, GRAY = 2'd3;
  state_t state;
  logic [2:0] prev;
  logic [3:0] a, b;
  logic g, e, m, l, n;
  logic [1:0] cls;
  logic [RUN_W-1:0] nlen;
  always_comb begin
    a = {1'b0, in_code};
    b = {1'b0, prev};
    g = $onehot(in_code ^ prev);
    m = a == b + 4'd1;
    l = b == a + 4'd1;
    e = (a == b + 4'd3) || (b == a + 4'd3);
    n = !(g || e || m || l);
    cls = m ? UP : l ? DOWN : g ? GRAY : NONE;
    nlen = cls == NONE ? '0 : cls != run_class ? RUN_W'(1) : &run_len ? run_len : run_len + RUN_W'(1);
  end
  // clear behaves exactly like reset; reset simply wins by being in the same branch
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state       <= EMPTY;
      prev        <= '0;
      out_valid   <= 1'b0;
      gray        <= 1'b0;
      excess_3    <= 1'b0;
      more        <= 1'b0;
      less        <= 1'b0;
      no_relation <= 1'b0;
      run_class   <= NONE;
      run_len     <= '0;
      lock        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      out_valid <= in_valid && state == HAVE_PREV;
      if (in_valid) begin
        prev  <= in_code;
        state <= HAVE_PREV;
        if (state == HAVE_PREV) begin
          gray        <= g;
          excess_3    <= e;
          more        <= m;
          less        <= l;
          no_relation <= n;
          run_class   <= cls;
          run_len     <= nlen;
          lock        <= cls != NONE && nlen >= RUN_W'(LOCK_LEN);
          err_cnt     <= (n && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_code_step_monitor.sv
// tb_code_step_monitor: directed and random steps checked against an arithmetic reference model
module tb_code_step_monitor;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0;
  logic [2:0] in_code = 0;
  logic out_valid, gray, excess_3, more, less, no_relation, lock;
  logic [1:0] run_class;
  logic [3:0] run_len;
  logic [7:0] err_cnt;
  int checks = 0, failures = 0;
  int m_has, m_prev, m_ov, m_g, m_e, m_m, m_l, m_n, m_rc, m_rl, m_lock, m_err;

  code_step_monitor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_code(in_code),
    .out_valid(out_valid), .gray(gray), .excess_3(excess_3), .more(more), .less(less),
    .no_relation(no_relation), .run_class(run_class), .run_len(run_len), .lock(lock),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int v, input int c, input int clr, input int rn);
    int d, cls, bits;
    if (!rn || clr) begin
      m_has = 0; m_prev = 0; m_ov = 0; m_g = 0; m_e = 0; m_m = 0; m_l = 0; m_n = 0;
      m_rc = 0; m_rl = 0; m_lock = 0; m_err = 0;
    end else if (!v) m_ov = 0;
    else if (!m_has) begin
      m_has = 1; m_prev = c; m_ov = 0;
    end else begin
      d = c - m_prev;
      bits = $countones(c ^ m_prev);
      m_m = d == 1;
      m_l = d == -1;
      m_e = d == 3 || d == -3;
      m_g = bits == 1;
      m_n = !(m_m || m_l || m_e || m_g);
      cls = m_m ? 1 : m_l ? 2 : m_g ? 3 : 0;
      m_rl = cls == 0 ? 0 : cls == m_rc ? (m_rl < 15 ? m_rl + 1 : 15) : 1;
      m_rc = cls;
      m_lock = cls != 0 && m_rl >= 4;
      m_err = m_err + m_n > 255 ? 255 : m_err + m_n;
      m_prev = c;
      m_ov = 1;
    end
  endtask

  task automatic step(input int v, input int c, input int clr = 0, input int rn = 1);
    @(negedge clk);
    in_valid = v[0]; in_code = c[2:0]; clear = clr[0]; rst_n = rn[0];
    @(posedge clk);
    model(v, c, clr, rn);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("gray", gray, m_g);
    chk("excess_3", excess_3, m_e);
    chk("more", more, m_m);
    chk("less", less, m_l);
    chk("no_relation", no_relation, m_n);
    chk("run_class", run_class, m_rc);
    chk("run_len", run_len, m_rl);
    chk("lock", lock, m_lock);
    chk("err_cnt", err_cnt, m_err);
  endtask

  initial begin
    step(0, 0, 0, 0);
    chk("reset_err", err_cnt, 0);
    for (int i = 0; i < 5; i++) step(1, i);
    chk("t1_len", run_len, 4);
    chk("t1_lock", lock, 1);
    step(1, 7); step(1, 6);
    chk("t2_less", less, 1);
    chk("t2_gray", gray, 1);
    step(1, 0); step(1, 2); step(1, 6); step(1, 4);
    chk("t3_class", run_class, 3);
    step(1, 1); step(1, 4);
    chk("t4_ex3", excess_3, 1);
    step(1, 0); step(1, 7);
    chk("t4_norel", no_relation, 1);
    for (int i = 0; i < 300; i++) step(1, (i % 2) ? 7 : 0);
    chk("t5_err_sat", err_cnt, 255);
    for (int i = 0; i < 40; i++) step(1, (i % 4 == 0) ? 0 : (i % 4 == 1) ? 2 : (i % 4 == 2) ? 6 : 4);
    chk("t5_len_sat", run_len, 15);
    for (int i = 0; i < 40; i++) step(1, (i / 8) % 2 ? 7 - i % 8 : i % 8);
    for (int i = 0; i < 6; i++) step(1, i);
    step(1, 3, 1);
    chk("t6_clear_len", run_len, 0);
    step(1, 5); step(1, 6);
    for (int i = 0; i < 6; i++) step(1, i);
    step(1, 3, 0, 0);
    step(1, 5); step(1, 6);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 60) == 0, $urandom_range(0, 80) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
